// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the multiply/divide unit: operation codes,
// FSM state encoding and the iteration count.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_e;

  localparam int MD_ITER = 32;

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Decode-to-multiply/divide handshake: request, operands, status and HI/LO.
interface mult_div_unit_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_start, md_op, op_a, op_b,
    input  md_busy, md_done, hi, lo
  );

  modport slave (
    input  md_start, md_op, op_a, op_b,
    output md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide with architectural HI/LO registers.
// Signed ops run on magnitudes; sign correction is applied in the FIX state.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md_if
);

  md_state_e   state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        is_signed_q, is_signed_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [33:0] base, addend, sum;
  logic        res_neg;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic        op_signed, op_div;

  // One adder serves both algorithms: multiply adds the multiplicand to the
  // upper accumulator half, divide adds the two's complement of the divisor
  // to the shifted partial remainder, so bit 33 doubles as the borrow.
  always_comb begin
    base   = is_div_q ? {1'b0, acc_q[63:31]} : {2'b00, acc_q[63:32]};
    addend = is_div_q ? ~{2'b00, opnd_q} : {2'b00, opnd_q};
    sum    = base + addend + {33'd0, is_div_q};
  end

  always_comb begin
    res_neg  = is_signed_q & (sign_a_q ^ sign_b_q);
    prod_fix = res_neg ? (~acc_q + 64'd1) : acc_q;
    // A zero divisor leaves the all-ones quotient untouched.
    quot_fix = (res_neg && !div_zero_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = (is_signed_q && sign_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    op_signed = (md_if.md_op == MD_MULT) || (md_if.md_op == MD_DIV);
    op_div    = (md_if.md_op == MD_DIV) || (md_if.md_op == MD_DIVU);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    div_zero_d  = div_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (md_if.md_start) begin
          case (md_if.md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d     = MD_CALC;
              count_d     = 5'd0;
              is_div_d    = op_div;
              is_signed_d = op_signed;
              sign_a_d    = op_signed & md_if.op_a[31];
              sign_b_d    = op_signed & md_if.op_b[31];
              div_zero_d  = (md_if.op_b == 32'd0);
              // Multiply: accumulator low half holds the multiplier.
              // Divide: accumulator low half holds the dividend.
              if (op_div) begin
                acc_d  = {32'd0, md_abs(md_if.op_a, op_signed)};
                opnd_d = md_abs(md_if.op_b, op_signed);
              end else begin
                acc_d  = {32'd0, md_abs(md_if.op_b, op_signed)};
                opnd_d = md_abs(md_if.op_a, op_signed);
              end
            end
            MD_MTHI: hi_d = md_if.op_a;
            MD_MTLO: lo_d = md_if.op_a;
            default: ;
          endcase
        end
      end

      MD_CALC: begin
        if (is_div_q) begin
          acc_d = sum[33] ? {acc_q[62:0], 1'b0} : {sum[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = acc_q[0] ? {sum[32:0], acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'(MD_ITER - 1)) begin
          state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MD_IDLE;
      count_q     <= 5'd0;
      acc_q       <= 64'd0;
      opnd_q      <= 32'd0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      div_zero_q  <= div_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
    end
  end

  assign md_if.md_busy = (state_q != MD_IDLE);
  assign md_if.md_done = done_q;
  assign md_if.hi      = hi_q;
  assign md_if.lo      = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU. Sits directly downstream of the register file: its operands are the two register-file read buses. It executes MULT/MULTU/DIV/DIVU in a fixed 33-cycle sequence, and MTHI/MTLO in a single cycle. It exposes HI/LO continuously for MFHI/MFLO selection in the execute stage. Control comes from decode via a start/busy/done handshake; a stall is raised while busy.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- md_start  input  1  request; sampled only while md_busy=0.
- md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- op_a  input  32  rs value (dividend / multiplicand / MTHI-MTLO source), from register read bus 1.
- op_b  input  32  rt value (divisor / multiplier), from register read bus 2.
- md_busy  output  1  high while an arithmetic op is in progress.
- md_done  output  1  one-cycle pulse when HI/LO receive an arithmetic result.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, md_start=1, op 0–3: capture operands, clear iteration counter, go to CALC.
  - For signed ops, capture magnitudes and record sign_a and sign_b.
- IDLE, md_start=1, op 4/5: write op_a to hi (MTHI) or lo (MTLO) at that edge.
  - Stay IDLE; no busy, no done.
- IDLE, reserved op: ignored; no state change.
- CALC: one iteration per cycle; counter 0..31; leave for FIX after iteration 31.
  - Multiply: shift-add on 64-bit accumulator; 33-bit adder carry kept.
  - Divide: restoring, 33-bit trial subtract of divisor from partial remainder; quotient bit shifted in.
- FIX: apply sign correction, write hi/lo, pulse md_done, return to IDLE.
  - MULT: negate 64-bit product if sign_a≠sign_b; hi=product[63:32], lo=product[31:0].
  - DIV: quotient negated if sign_a≠sign_b; remainder takes sign of dividend; lo=quotient, hi=remainder.
  - Unsigned ops: no correction.
- Divide by zero (op_b=0, DIV or DIVU): full latency, no trap; lo=32'hFFFF_FFFF, hi=op_a.
  - This falls out of the restoring algorithm on magnitudes; for DIV, sign correction still applies to the remainder only, so hi=op_a.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps, no exception).
- md_start while busy: ignored. Operand changes after the capture edge: no effect.
- hi/lo change only on FIX exit, MTHI/MTLO, or reset.

## Timing
- Reset: state=IDLE, counter=0, md_busy=0, md_done=0, hi=0, lo=0.
- Reset mid-operation aborts: next cycle is IDLE, hi/lo=0, no md_done.
- Reset together with md_start: reset wins.
- Arithmetic op accepted at edge E0.
  - md_busy=1 after E0.
  - Edges E1..E32 perform iterations; E32 enters FIX.
  - E33 writes hi/lo and returns to IDLE.
  - After E33: md_busy=0, md_done=1 for exactly one cycle, results visible.
  - Latency is 33 cycles, start to result.
- A new md_start is accepted in the md_done cycle (back-to-back issue); throughput is one op per 33 cycles.
- MTHI/MTLO: value visible on hi/lo one cycle after the accepting edge.
- hi/lo are registered outputs; no combinational path from inputs.

## Structure
- Shared package mips_pkg holds:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding (MD_IDLE, MD_CALC, MD_FIX);
  - the MD_ITER=32 constant.
- Single module; no sub-module is natural. The shared 33-bit add/subtract datapath stays inline.

## Test plan
- MULT op_a=0xFFFF_FFFF, op_b=3 -> md_done 33 cycles after start; hi=0xFFFF_FFFF, lo=0xFFFF_FFFD.
- MULTU op_a=op_b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; md_busy high exactly 33 cycles.
- DIV op_a=0xFFFF_FFF9 (−7), op_b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. Then DIVU op_a=100, op_b=0 -> lo=0xFFFF_FFFF, hi=0x0000_0064.
- MTHI op_a=0x1234_5678, then MTLO op_a=0xCAFE_F00D on consecutive cycles -> hi and lo updated on the next cycles; md_busy and md_done never assert.
- Start MULTU 7×6, then assert md_start with MTLO at cycle 5 -> ignored; result hi=0, lo=42; lo not overwritten by the MTLO.
- Start DIVU 50/5, reset at cycle 10 -> IDLE next cycle, hi=lo=0, no md_done. A new DIVU 50/5 then returns lo=10, hi=0.
